// File: rtl/rice_core_csr_access_ctrl.sv
// rice_core_csr_access_ctrl
// Sequences one CSR instruction (CSRRW/CSRRS/CSRRC, register or immediate
// form) from execute onto the 12-bit-address CSR bus as a read phase and a
// write phase. It applies the privilege and read-only checks before any bus
// access and returns the old CSR value, or flags an illegal instruction.
//
// Optional build macro:
//   RICE_CSR_ACCESS_TIMEOUT_EN - bounds the response wait to TIMEOUT_CYCLES;
//   an expired wait completes as illegal, and the DRAIN state then swallows
//   the late response. Without it the block waits for a response forever.
module rice_core_csr_access_ctrl #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [1:0]      i_privilege_level,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [11:0]     i_address,
    input  logic [XLEN-1:0] i_operand,
    input  logic            i_read_skip,
    input  logic            i_write_skip,
    input  logic            i_flush,
    output logic            o_done,
    output logic            o_illegal,
    output logic [XLEN-1:0] o_rd_value,
    output logic            o_csr_request_valid,
    input  logic            i_csr_request_ready,
    output logic [11:0]     o_csr_address,
    output logic            o_csr_write,
    output logic [XLEN-1:0] o_csr_write_data,
    input  logic            i_csr_response_valid,
    input  logic [XLEN-1:0] i_csr_read_data,
    input  logic            i_csr_error
);

    localparam logic [1:0] OP_RW = 2'd1;
    localparam logic [1:0] OP_RS = 2'd2;
    localparam logic [1:0] OP_RC = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ_REQ,
        S_READ_RSP,
        S_WRITE_REQ,
        S_WRITE_RSP,
        S_DONE
`ifdef RICE_CSR_ACCESS_TIMEOUT_EN
        ,
        S_DRAIN
`endif
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // Captured instruction
    logic [1:0]        op_q;
    logic [11:0]       addr_q;
    logic [XLEN-1:0]   operand_q;
    logic              rskip_q;
    logic              wskip_q;
    logic [1:0]        priv_q;

    // Working state
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   old_d;
    logic              discard_q;
    logic              discard_d;

    // Next values of the registered outputs
    logic              done_d;
    logic              illegal_d;
    logic [XLEN-1:0]   rd_d;
    logic [11:0]       addr_d;
    logic              write_d;
    logic [XLEN-1:0]   wdata_d;

    logic              accept;
    logic              rskip_in;
    logic              wskip_in;
    logic              chk_illegal;
    logic              flush_now;
    logic              fin_illegal;

`ifdef RICE_CSR_ACCESS_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0]   cnt_q;
    logic [TO_W-1:0]   cnt_d;
    logic              drain_q;
    logic              drain_d;
    logic              timeout_hit;

    // Response wait has used up its budget
    always_comb timeout_hit = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic              unused_timeout_cfg;
    assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
`endif

    // Write data from the old value and the operand
    function automatic logic [XLEN-1:0] write_value(
        input logic [1:0]      op,
        input logic [XLEN-1:0] old,
        input logic [XLEN-1:0] operand
    );
        logic [XLEN-1:0] v;
        case (op)
            OP_RS:   v = old | operand;
            OP_RC:   v = old & ~operand;
            default: v = operand;
        endcase
        return v;
    endfunction

    // Effective skips: read skip only for RW, write skip only for RS/RC
    always_comb begin
        accept   = (state_q == S_IDLE) && i_valid;
        rskip_in = i_read_skip && (i_op == OP_RW);
        wskip_in = i_write_skip && ((i_op == OP_RS) || (i_op == OP_RC));
    end

    // Reserved op, insufficient privilege, or write to a read-only CSR
    always_comb begin
        chk_illegal = (op_q == 2'd0)
                   || (addr_q[9:8] > priv_q)
                   || ((addr_q[11:10] == 2'b11) && !wskip_q);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, working registers and next output values
    always_comb begin
        state_d     = state_q;
        old_d       = old_q;
        discard_d   = discard_q;
        fin_illegal = 1'b0;
        done_d      = 1'b0;
        illegal_d   = 1'b0;
        rd_d        = '0;
        addr_d      = o_csr_address;
        write_d     = o_csr_write;
        wdata_d     = o_csr_write_data;
        flush_now   = discard_q | i_flush;
`ifdef RICE_CSR_ACCESS_TIMEOUT_EN
        drain_d     = drain_q;
        cnt_d       = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    state_d = S_CHECK;
                    old_d   = '0;
                end
            end
            S_CHECK: begin
                if (chk_illegal) begin
                    state_d     = S_DONE;
                    fin_illegal = 1'b1;
                end else if (flush_now) begin
                    // Nothing issued yet, so a flushed instruction stops here
                    state_d = S_DONE;
                end else if (rskip_q) begin
                    state_d = S_WRITE_REQ;
                    addr_d  = addr_q;
                    write_d = 1'b1;
                    wdata_d = write_value(op_q, '0, operand_q);
                end else begin
                    state_d = S_READ_REQ;
                    addr_d  = addr_q;
                    write_d = 1'b0;
                end
            end
            S_READ_REQ: begin
                if (i_csr_request_ready) begin
                    state_d = S_READ_RSP;
                end
            end
            S_READ_RSP: begin
                if (i_csr_response_valid) begin
                    if (i_csr_error) begin
                        state_d     = S_DONE;
                        fin_illegal = 1'b1;
                    end else begin
                        old_d = i_csr_read_data;
                        if (wskip_q || flush_now) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WRITE_REQ;
                            write_d = 1'b1;
                            wdata_d = write_value(op_q, i_csr_read_data, operand_q);
                        end
                    end
                end
`ifdef RICE_CSR_ACCESS_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d     = S_DONE;
                    fin_illegal = 1'b1;
                    drain_d     = 1'b1;
                end
`endif
            end
            S_WRITE_REQ: begin
                if (i_csr_request_ready) begin
                    state_d = S_WRITE_RSP;
                end
            end
            S_WRITE_RSP: begin
                if (i_csr_response_valid) begin
                    state_d     = S_DONE;
                    fin_illegal = i_csr_error;
                end
`ifdef RICE_CSR_ACCESS_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d     = S_DONE;
                    fin_illegal = 1'b1;
                    drain_d     = 1'b1;
                end
`endif
            end
            S_DONE: begin
`ifdef RICE_CSR_ACCESS_TIMEOUT_EN
                state_d = drain_q ? S_DRAIN : S_IDLE;
`else
                state_d = S_IDLE;
`endif
            end
`ifdef RICE_CSR_ACCESS_TIMEOUT_EN
            S_DRAIN: begin
                if (i_csr_response_valid) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Discard is sticky while busy and clears on return to IDLE
        if ((state_q != S_IDLE) && i_flush) begin
            discard_d = 1'b1;
        end
        if (state_d == S_IDLE) begin
            discard_d = 1'b0;
        end

        // Completion report, suppressed for discarded instructions
        if (state_d == S_DONE) begin
            done_d    = !flush_now;
            illegal_d = fin_illegal && !flush_now;
            rd_d      = (fin_illegal || flush_now) ? '0 : old_d;
        end

`ifdef RICE_CSR_ACCESS_TIMEOUT_EN
        if (state_d == S_IDLE) begin
            drain_d = 1'b0;
        end
        if ((state_d == state_q) && ((state_q == S_READ_RSP) || (state_q == S_WRITE_RSP))) begin
            cnt_d = cnt_q + TO_W'(1);
        end
`endif
    end

    // Instruction capture on acceptance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q      <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            rskip_q   <= 1'b0;
            wskip_q   <= 1'b0;
            priv_q    <= '0;
        end else if (accept) begin
            op_q      <= i_op;
            addr_q    <= i_address;
            operand_q <= i_operand;
            rskip_q   <= rskip_in;
            wskip_q   <= wskip_in;
            priv_q    <= i_privilege_level;
        end
    end

    // Working registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            old_q     <= '0;
            discard_q <= 1'b0;
        end else begin
            old_q     <= old_d;
            discard_q <= discard_d;
        end
    end

`ifdef RICE_CSR_ACCESS_TIMEOUT_EN
    // Response-wait counter and drain marker
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end
`endif

    // Registered outputs, derived from the next state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ready             <= 1'b1;
            o_done              <= 1'b0;
            o_illegal           <= 1'b0;
            o_rd_value          <= '0;
            o_csr_request_valid <= 1'b0;
            o_csr_address       <= '0;
            o_csr_write         <= 1'b0;
            o_csr_write_data    <= '0;
        end else begin
            o_ready             <= (state_d == S_IDLE);
            o_done              <= done_d;
            o_illegal           <= illegal_d;
            o_rd_value          <= rd_d;
            o_csr_request_valid <= (state_d == S_READ_REQ) || (state_d == S_WRITE_REQ);
            o_csr_address       <= addr_d;
            o_csr_write         <= write_d;
            o_csr_write_data    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_rice_core_csr_access_ctrl.sv
// Directed bench for rice_core_csr_access_ctrl with a zero-wait CSR slave.
// Expected bus requests and completions are queued before each instruction
// and popped by the slave/monitor process when the DUT produces them.
module tb_rice_core_csr_access_ctrl;

    localparam int unsigned XLEN = 32;
    localparam logic [1:0]  OP_RW = 2'd1;
    localparam logic [1:0]  OP_RS = 2'd2;
    localparam logic [1:0]  OP_RC = 2'd3;

    typedef struct packed {
        logic        write;
        logic [11:0] addr;
        logic [31:0] data;
    } bus_t;

    typedef struct packed {
        logic        illegal;
        logic [31:0] rd;
    } done_t;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic [1:0]      i_privilege_level;
    logic            i_valid;
    logic            o_ready;
    logic [1:0]      i_op;
    logic [11:0]     i_address;
    logic [XLEN-1:0] i_operand;
    logic            i_read_skip;
    logic            i_write_skip;
    logic            i_flush;
    logic            o_done;
    logic            o_illegal;
    logic [XLEN-1:0] o_rd_value;
    logic            o_csr_request_valid;
    logic            i_csr_request_ready;
    logic [11:0]     o_csr_address;
    logic            o_csr_write;
    logic [XLEN-1:0] o_csr_write_data;
    logic            i_csr_response_valid = 1'b0;
    logic [XLEN-1:0] i_csr_read_data = '0;
    logic            i_csr_error = 1'b0;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;

    bus_t  exp_bus_q[$];
    done_t exp_done_q[$];

    logic        sl_drop  = 1'b0;
    logic        sl_rerr  = 1'b0;
    logic        sl_werr  = 1'b0;
    logic        sl_late  = 1'b0;
    logic [31:0] sl_rdata = '0;

    always #5 i_clk = ~i_clk;

    rice_core_csr_access_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(64)) dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_privilege_level    (i_privilege_level),
        .i_valid              (i_valid),
        .o_ready              (o_ready),
        .i_op                 (i_op),
        .i_address            (i_address),
        .i_operand            (i_operand),
        .i_read_skip          (i_read_skip),
        .i_write_skip         (i_write_skip),
        .i_flush              (i_flush),
        .o_done               (o_done),
        .o_illegal            (o_illegal),
        .o_rd_value           (o_rd_value),
        .o_csr_request_valid  (o_csr_request_valid),
        .i_csr_request_ready  (i_csr_request_ready),
        .o_csr_address        (o_csr_address),
        .o_csr_write          (o_csr_write),
        .o_csr_write_data     (o_csr_write_data),
        .i_csr_response_valid (i_csr_response_valid),
        .i_csr_read_data      (i_csr_read_data),
        .i_csr_error          (i_csr_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_bus(input logic w, input logic [11:0] a, input logic [31:0] d);
        bus_t b;
        b.write = w;
        b.addr  = a;
        b.data  = d;
        exp_bus_q.push_back(b);
    endtask

    task automatic exp_done(input logic ill, input logic [31:0] rd);
        done_t d;
        d.illegal = ill;
        d.rd      = rd;
        exp_done_q.push_back(d);
    endtask

    // Zero-wait slave plus completion monitor
    always @(posedge i_clk) begin
        logic        hs;
        logic        hs_w;
        logic [11:0] hs_a;
        logic [31:0] hs_d;
        logic        dn;
        logic        dn_ill;
        logic [31:0] dn_rd;
        bus_t        eb;
        done_t       ed;
        hs     = o_csr_request_valid && i_csr_request_ready;
        hs_w   = o_csr_write;
        hs_a   = o_csr_address;
        hs_d   = o_csr_write_data;
        #1;
        dn     = o_done;
        dn_ill = o_illegal;
        dn_rd  = o_rd_value;
        i_csr_response_valid = 1'b0;
        i_csr_error          = 1'b0;
        i_csr_read_data      = '0;
        if (hs) begin
            chk("bus_request_expected", 64'(exp_bus_q.size() != 0), 64'd1);
            if (exp_bus_q.size() != 0) begin
                eb = exp_bus_q.pop_front();
                chk("bus_write_flag", 64'(hs_w), 64'(eb.write));
                chk("bus_address", 64'(hs_a), 64'(eb.addr));
                if (eb.write) chk("bus_write_data", 64'(hs_d), 64'(eb.data));
            end
            if (!sl_drop) begin
                i_csr_response_valid = 1'b1;
                i_csr_error          = hs_w ? sl_werr : sl_rerr;
                i_csr_read_data      = hs_w ? 32'h0 : sl_rdata;
            end
        end
        if (sl_late) begin
            i_csr_response_valid = 1'b1;
            i_csr_read_data      = 32'hDEAD_BEEF;
            sl_late              = 1'b0;
        end
        if (dn) begin
            n_done++;
            chk("done_expected", 64'(exp_done_q.size() != 0), 64'd1);
            if (exp_done_q.size() != 0) begin
                ed = exp_done_q.pop_front();
                chk("done_illegal", 64'(dn_ill), 64'(ed.illegal));
                chk("done_rd_value", 64'(dn_rd), 64'(ed.rd));
            end
        end
    end

    task automatic issue(input logic [1:0] priv, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] operand, input logic rskip, input logic wskip);
        chk("ready_before_issue", 64'(o_ready), 64'd1);
        i_privilege_level = priv;
        i_op              = op;
        i_address         = addr;
        i_operand         = operand;
        i_read_skip       = rskip;
        i_write_skip      = wskip;
        i_valid           = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid      = 1'b0;
        i_read_skip  = 1'b0;
        i_write_skip = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int cnt;
        cnt = 1;
        while (o_done !== 1'b1 && cnt < 400) begin
            @(posedge i_clk);
            #1;
            cnt++;
        end
        chk({tag, "_latency"}, 64'(cnt), 64'(lat));
        @(posedge i_clk);
        #1;
        chk({tag, "_bus_drained"}, 64'(exp_bus_q.size()), 64'd0);
        chk({tag, "_done_drained"}, 64'(exp_done_q.size()), 64'd0);
    endtask

    task automatic wait_ready(input string tag, input int bound);
        int cnt;
        cnt = 0;
        while (o_ready !== 1'b1 && cnt < bound) begin
            @(posedge i_clk);
            #1;
            cnt++;
        end
        chk(tag, 64'(o_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        i_rst_n             = 1'b0;
        i_privilege_level   = 2'd3;
        i_valid             = 1'b0;
        i_op                = '0;
        i_address           = '0;
        i_operand           = '0;
        i_read_skip         = 1'b0;
        i_write_skip        = 1'b0;
        i_flush             = 1'b0;
        i_csr_request_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_ctrl", 64'({o_ready, o_done, o_illegal, o_csr_request_valid, o_csr_write}), 64'b10000);
        chk("reset_data", {o_rd_value, o_csr_write_data}, 64'd0);
        chk("reset_address", 64'(o_csr_address), 64'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // CSRRS read+write
        sl_rdata = 32'h1800;
        exp_bus(1'b0, 12'h300, 32'h0);
        exp_bus(1'b1, 12'h300, 32'h1808);
        exp_done(1'b0, 32'h1800);
        issue(2'd3, OP_RS, 12'h300, 32'h8, 1'b0, 1'b0);
        wait_done("rs_rw", 6);

        // CSRRW with read skip: write only
        exp_bus(1'b1, 12'h341, 32'h100);
        exp_done(1'b0, 32'h0);
        issue(2'd3, OP_RW, 12'h341, 32'h100, 1'b1, 1'b0);
        wait_done("rw_rskip", 4);

        // User mode to machine CSR
        exp_done(1'b1, 32'h0);
        issue(2'd0, OP_RS, 12'h305, 32'h1, 1'b0, 1'b0);
        wait_done("user_priv", 2);

        // Write to read-only CSR
        exp_done(1'b1, 32'h0);
        issue(2'd3, OP_RC, 12'hF14, 32'h1, 1'b0, 1'b0);
        wait_done("ro_write", 2);

        // Read-only CSR with write skipped is legal
        sl_rdata = 32'hABCD;
        exp_bus(1'b0, 12'hF14, 32'h0);
        exp_done(1'b0, 32'hABCD);
        issue(2'd3, OP_RS, 12'hF14, 32'h0, 1'b0, 1'b1);
        wait_done("ro_read", 4);

        // Read response error
        sl_rerr = 1'b1;
        exp_bus(1'b0, 12'h7C0, 32'h0);
        exp_done(1'b1, 32'h0);
        issue(2'd3, OP_RW, 12'h7C0, 32'h5, 1'b0, 1'b0);
        wait_done("read_err", 4);
        sl_rerr = 1'b0;

        // Reserved op
        exp_done(1'b1, 32'h0);
        issue(2'd3, 2'd0, 12'h300, 32'h1, 1'b0, 1'b0);
        wait_done("op_zero", 2);

        // CSRRC, flush asserted during the IDLE acceptance cycle has no effect
        sl_rdata = 32'h1808;
        exp_bus(1'b0, 12'h300, 32'h0);
        exp_bus(1'b1, 12'h300, 32'h1008);
        exp_done(1'b0, 32'h1808);
        i_flush = 1'b1;
        issue(2'd3, OP_RC, 12'h300, 32'h0F00, 1'b0, 1'b0);
        i_flush = 1'b0;
        wait_done("rc_idle_flush", 6);

        // Read skip ignored for RS
        sl_rdata = 32'h10;
        exp_bus(1'b0, 12'h340, 32'h0);
        exp_bus(1'b1, 12'h340, 32'h11);
        exp_done(1'b0, 32'h10);
        issue(2'd3, OP_RS, 12'h340, 32'h1, 1'b1, 1'b0);
        wait_done("rs_rskip_ignored", 6);

        // Write skip ignored for RW
        sl_rdata = 32'h11;
        exp_bus(1'b0, 12'h340, 32'h0);
        exp_bus(1'b1, 12'h340, 32'h0);
        exp_done(1'b0, 32'h11);
        issue(2'd3, OP_RW, 12'h340, 32'h0, 1'b0, 1'b1);
        wait_done("rw_wskip_ignored", 6);

        // Write response error
        sl_werr = 1'b1;
        exp_bus(1'b1, 12'h341, 32'h200);
        exp_done(1'b1, 32'h0);
        issue(2'd3, OP_RW, 12'h341, 32'h200, 1'b1, 1'b0);
        wait_done("write_err", 4);
        sl_werr = 1'b0;

        // Privilege equal to the CSR level is legal
        sl_rdata = 32'h55;
        exp_bus(1'b0, 12'h141, 32'h0);
        exp_done(1'b0, 32'h55);
        issue(2'd1, OP_RS, 12'h141, 32'h0, 1'b0, 1'b1);
        wait_done("priv_equal", 4);

        // Flush while the read request is stalled
        sl_rdata            = 32'h77;
        n0                  = n_done;
        i_csr_request_ready = 1'b0;
        exp_bus(1'b0, 12'h300, 32'h0);
        issue(2'd3, OP_RS, 12'h300, 32'h1, 1'b0, 1'b0);
        @(posedge i_clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(o_csr_request_valid), 64'd1);
            chk("stall_addr", 64'({o_csr_write, o_csr_address}), 64'h300);
            i_flush = (i == 1);
            @(posedge i_clk);
            #1;
        end
        i_flush             = 1'b0;
        i_csr_request_ready = 1'b1;
        wait_ready("flush_ready_back", 20);
        @(posedge i_clk);
        #1;
        chk("flush_no_done", 64'(n_done - n0), 64'd0);
        chk("flush_bus_drained", 64'(exp_bus_q.size()), 64'd0);

        // Reset in the middle of an instruction
        n0 = n_done;
        issue(2'd3, OP_RS, 12'h300, 32'h1, 1'b0, 1'b0);
        @(posedge i_clk);
        #1;
        chk("pre_reset_valid", 64'(o_csr_request_valid), 64'd1);
        i_rst_n = 1'b0;
        #1;
        chk("midreset_ctrl", 64'({o_ready, o_done, o_csr_request_valid}), 64'b100);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("midreset_no_done", 64'(n_done - n0), 64'd0);
        chk("midreset_ready", 64'(o_ready), 64'd1);

`ifdef RICE_CSR_ACCESS_TIMEOUT_EN
        // Response timeout, then drain of the late response
        sl_drop = 1'b1;
        exp_bus(1'b0, 12'h300, 32'h0);
        exp_done(1'b1, 32'h0);
        issue(2'd3, OP_RS, 12'h300, 32'h1, 1'b0, 1'b0);
        wait_done("timeout", 67);
        sl_drop = 1'b0;
        chk("drain_not_ready", 64'(o_ready), 64'd0);
        repeat (3) @(posedge i_clk);
        #1;
        chk("drain_still_waiting", 64'(o_ready), 64'd0);
        sl_late = 1'b1;
        wait_ready("drain_release", 10);
`endif

        // Normal instruction after recovery
        sl_rdata = 32'h1234;
        exp_bus(1'b0, 12'h300, 32'h0);
        exp_bus(1'b1, 12'h300, 32'h1235);
        exp_done(1'b0, 32'h1234);
        issue(2'd3, OP_RS, 12'h300, 32'h1, 1'b0, 1'b0);
        wait_done("after_recovery", 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
